// File: rtl/intersection_model_if.sv
// Light/sensor interface between a traffic controller and the intersection.
//   Ga,Ya,Ra : street A lamps, driven by the controller
//   Gb,Yb,Rb : street B lamps, driven by the controller
//   Sa,Sb    : vehicle-present sensors, driven by the intersection
// master modport = controller side, slave modport = intersection side.
interface intersection_model_if;
  logic Ga, Ya, Ra;
  logic Gb, Yb, Rb;
  logic Sa, Sb;

  modport master (
    output Ga, Ya, Ra, Gb, Yb, Rb,
    input  Sa, Sb
  );

  modport slave (
    input  Ga, Ya, Ra, Gb, Yb, Rb,
    output Sa, Sb
  );
endinterface

// File: rtl/intersection_model.sv
// Behavioural model of a two-street intersection, sitting on the far side of
// the light/sensor interface from the traffic controller.
//   clk, rst     : clock; synchronous active-high reset
//   arr_a, arr_b : vehicle arrival pulses (one vehicle per high cycle)
//   bus (slave)  : lamps in (Ga..Rb), sensors out (Sa, Sb)
//   qa, qb       : per-street queue depth
//   ovf_a, ovf_b : sticky, arrival dropped on a full queue
//   fault        : sticky, illegal lamp vector, bad phase order or green conflict
// Optional build macro INTERSECTION_STATS_EN adds served_a/served_b departure
// counters (16 bit, wrapping) and max_qa (peak street A depth since reset).
module intersection_model #(
  parameter int unsigned QW            = 4,
  parameter int unsigned DEPART_CYCLES = 2,
  parameter int unsigned YELLOW_SERVES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arr_a,
  input  logic                arr_b,
  intersection_model_if.slave bus,
  output logic [QW-1:0]       qa,
  output logic [QW-1:0]       qb,
  output logic                ovf_a,
  output logic                ovf_b,
  output logic                fault
`ifdef INTERSECTION_STATS_EN
  ,
  output logic [15:0]         served_a,
  output logic [15:0]         served_b,
  output logic [QW-1:0]       max_qa
`endif
);

  localparam int unsigned TW = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
  localparam logic [TW-1:0] TLast = TW'(DEPART_CYCLES - 1);
  localparam logic [QW-1:0] QMax  = '1;

  // Lamp tracker states
  localparam logic [1:0] StUnk = 2'd0;
  localparam logic [1:0] StRed = 2'd1;
  localparam logic [1:0] StGrn = 2'd2;
  localparam logic [1:0] StYel = 2'd3;

  // Returns {valid, state}. Anything not strictly one-hot (including X/Z, which
  // never matches a case item) is invalid.
  function automatic logic [2:0] lamp_decode(input logic [2:0] gyr);
    logic [2:0] res;
    case (gyr)
      3'b100:  res = {1'b1, StGrn};
      3'b010:  res = {1'b1, StYel};
      3'b001:  res = {1'b1, StRed};
      default: res = {1'b0, StUnk};
    endcase
    return res;
  endfunction

  // Phase order R->G->Y->R plus self-loops; an unknown tracker accepts anything.
  function automatic logic order_ok(input logic [1:0] cur, input logic [1:0] nxt);
    logic ok;
    ok = 1'b1;
    if (cur != nxt) begin
      case (cur)
        StRed:   ok = (nxt == StGrn);
        StGrn:   ok = (nxt == StYel);
        StYel:   ok = (nxt == StRed);
        default: ok = 1'b1;
      endcase
    end
    return ok;
  endfunction

  logic [QW-1:0] qa_q, qa_d, qb_q, qb_d;
  logic [TW-1:0] tmr_a_q, tmr_a_d, tmr_b_q, tmr_b_d;
  logic          ovf_a_q, ovf_a_d, ovf_b_q, ovf_b_d;
  logic          fault_q, fault_d;
  logic          sa_q, sb_q;
  logic [1:0]    trk_a_q, trk_a_d, trk_b_q, trk_b_d;

  logic          win_a, win_b, busy_a, busy_b, dep_a, dep_b;
  logic          viol_a, viol_b, conflict;
  logic [2:0]    dec_a, dec_b;

  // Service windows and departure pacing
  always_comb begin
    win_a  = bus.Ga | ((YELLOW_SERVES != 0) & bus.Ya);
    win_b  = bus.Gb | ((YELLOW_SERVES != 0) & bus.Yb);
    busy_a = win_a & (qa_q != '0);
    busy_b = win_b & (qb_q != '0);
    dep_a  = busy_a & (tmr_a_q == TLast);
    dep_b  = busy_b & (tmr_b_q == TLast);
    // A closed window or empty queue forfeits any partial service progress.
    tmr_a_d = (busy_a && !dep_a) ? tmr_a_q + 1'b1 : '0;
    tmr_b_d = (busy_b && !dep_b) ? tmr_b_q + 1'b1 : '0;
  end

  // Queue update: simultaneous arrival and departure cancel, never overflow.
  always_comb begin
    qa_d    = qa_q;
    ovf_a_d = ovf_a_q;
    if (arr_a && !dep_a) begin
      if (qa_q == QMax) ovf_a_d = 1'b1;
      else              qa_d    = qa_q + 1'b1;
    end else if (dep_a && !arr_a) begin
      qa_d = qa_q - 1'b1;
    end

    qb_d    = qb_q;
    ovf_b_d = ovf_b_q;
    if (arr_b && !dep_b) begin
      if (qb_q == QMax) ovf_b_d = 1'b1;
      else              qb_d    = qb_q + 1'b1;
    end else if (dep_b && !arr_b) begin
      qb_d = qb_q - 1'b1;
    end
  end

  // Lamp trackers and fault detection
  always_comb begin
    dec_a   = lamp_decode({bus.Ga, bus.Ya, bus.Ra});
    dec_b   = lamp_decode({bus.Gb, bus.Yb, bus.Rb});
    trk_a_d = trk_a_q;
    trk_b_d = trk_b_q;
    viol_a  = 1'b0;
    viol_b  = 1'b0;

    // Invalid vector: hold the tracker. Bad order: flag, but still follow lamps.
    if (!dec_a[2]) begin
      viol_a = 1'b1;
    end else begin
      trk_a_d = dec_a[1:0];
      viol_a  = !order_ok(trk_a_q, dec_a[1:0]);
    end

    if (!dec_b[2]) begin
      viol_b = 1'b1;
    end else begin
      trk_b_d = dec_b[1:0];
      viol_b  = !order_ok(trk_b_q, dec_b[1:0]);
    end

    conflict = bus.Ga & bus.Gb;
    fault_d  = fault_q | viol_a | viol_b | conflict;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qa_q    <= '0;
      qb_q    <= '0;
      tmr_a_q <= '0;
      tmr_b_q <= '0;
      ovf_a_q <= 1'b0;
      ovf_b_q <= 1'b0;
      fault_q <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      trk_a_q <= StUnk;
      trk_b_q <= StUnk;
    end else begin
      qa_q    <= qa_d;
      qb_q    <= qb_d;
      tmr_a_q <= tmr_a_d;
      tmr_b_q <= tmr_b_d;
      ovf_a_q <= ovf_a_d;
      ovf_b_q <= ovf_b_d;
      fault_q <= fault_d;
      // Sensors follow the registered count, one cycle behind it.
      sa_q    <= (qa_q != '0);
      sb_q    <= (qb_q != '0);
      trk_a_q <= trk_a_d;
      trk_b_q <= trk_b_d;
    end
  end

  assign qa     = qa_q;
  assign qb     = qb_q;
  assign ovf_a  = ovf_a_q;
  assign ovf_b  = ovf_b_q;
  assign fault  = fault_q;
  assign bus.Sa = sa_q;
  assign bus.Sb = sb_q;

`ifdef INTERSECTION_STATS_EN
  logic [15:0]   served_a_q, served_b_q;
  logic [QW-1:0] max_qa_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      served_a_q <= '0;
      served_b_q <= '0;
      max_qa_q   <= '0;
    end else begin
      if (dep_a) served_a_q <= served_a_q + 16'd1;
      if (dep_b) served_b_q <= served_b_q + 16'd1;
      // Compare against the next count so the peak is current, not a cycle late.
      if (qa_d > max_qa_q) max_qa_q <= qa_d;
    end
  end

  assign served_a = served_a_q;
  assign served_b = served_b_q;
  assign max_qa   = max_qa_q;
`endif

endmodule

// File: tb/tb_intersection_model.sv
module tb_intersection_model;

  localparam int unsigned QW = 4;

  localparam logic [2:0] LR   = 3'b001;
  localparam logic [2:0] LY   = 3'b010;
  localparam logic [2:0] LG   = 3'b100;
  localparam logic [2:0] LOff = 3'b000;
  localparam logic [2:0] LGY  = 3'b110;

  localparam int SelQa = 0, SelQb = 1, SelSa = 2, SelSb = 3, SelOvfA = 4, SelOvfB = 5;
  localparam int SelFault = 6, SelSrvA = 7, SelSrvB = 8, SelMaxQa = 9;

  logic          clk;
  logic          rst;
  logic          arr_a, arr_b;
  logic [QW-1:0] qa, qb;
  logic          ovf_a, ovf_b, fault;
`ifdef INTERSECTION_STATS_EN
  logic [15:0]   served_a, served_b;
  logic [QW-1:0] max_qa;
`endif

  intersection_model_if bus ();

  intersection_model #(
    .QW            (QW),
    .DEPART_CYCLES (2),
    .YELLOW_SERVES (0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .arr_a    (arr_a),
    .arr_b    (arr_b),
    .bus      (bus),
    .qa       (qa),
    .qb       (qb),
    .ovf_a    (ovf_a),
    .ovf_b    (ovf_b),
    .fault    (fault)
`ifdef INTERSECTION_STATS_EN
    ,
    .served_a (served_a),
    .served_b (served_b),
    .max_qa   (max_qa)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic logic [31:0] observe(input int sel);
    logic [31:0] v;
    v = 'x;
    case (sel)
      SelQa:    v = 32'(qa);
      SelQb:    v = 32'(qb);
      SelSa:    v = 32'(bus.Sa);
      SelSb:    v = 32'(bus.Sb);
      SelOvfA:  v = 32'(ovf_a);
      SelOvfB:  v = 32'(ovf_b);
      SelFault: v = 32'(fault);
`ifdef INTERSECTION_STATS_EN
      SelSrvA:  v = 32'(served_a);
      SelSrvB:  v = 32'(served_b);
      SelMaxQa: v = 32'(max_qa);
`endif
      default:  v = 'x;
    endcase
    return v;
  endfunction

  task automatic expect_v(input string tag, input int sel, input logic [31:0] e);
    exp_t t;
    t.tag = tag;
    t.sel = sel;
    t.exp = e;
    sb.push_back(t);
  endtask

  task automatic check_sb();
    exp_t        t;
    logic [31:0] o;
    while (sb.size() > 0) begin
      t = sb.pop_front();
      o = observe(t.sel);
      n_total++;
      assert (o === t.exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", t.tag, o, t.exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lamps(input logic [2:0] a, input logic [2:0] b);
    {bus.Ga, bus.Ya, bus.Ra} = a;
    {bus.Gb, bus.Yb, bus.Rb} = b;
  endtask

  initial begin
    rst = 1'b1; arr_a = 1'b0; arr_b = 1'b0;
    lamps(LG, LR);
    tick(2);
    expect_v("rst_qa", SelQa, 0);      expect_v("rst_qb", SelQb, 0);
    expect_v("rst_sa", SelSa, 0);      expect_v("rst_sb", SelSb, 0);
    expect_v("rst_fault", SelFault, 0);
    expect_v("rst_ovf_a", SelOvfA, 0); expect_v("rst_ovf_b", SelOvfB, 0);
    check_sb();

    // Arrivals on red street A
    rst = 1'b0;
    lamps(LR, LG);
    tick(1);
    arr_a = 1'b1;
    tick(1); expect_v("arr1_qa", SelQa, 1); expect_v("arr1_sa_lag", SelSa, 0); check_sb();
    tick(1); expect_v("arr2_qa", SelQa, 2); expect_v("arr2_sa", SelSa, 1); check_sb();
    tick(1); expect_v("arr3_qa", SelQa, 3); check_sb();
    arr_a = 1'b0;
    tick(3);
    expect_v("hold_qa", SelQa, 3); expect_v("hold_sa", SelSa, 1);
    expect_v("hold_qb", SelQb, 0); expect_v("hold_fault", SelFault, 0);
    check_sb();

    // Hand green to A and drain at one vehicle per two cycles
    lamps(LR, LY); tick(1);
    lamps(LR, LR); tick(1);
    lamps(LG, LR);
    tick(1); expect_v("drain_e1", SelQa, 3); check_sb();
    tick(1); expect_v("drain_e2", SelQa, 2); check_sb();
    tick(2); expect_v("drain_e4", SelQa, 1); check_sb();
    tick(2); expect_v("drain_e6", SelQa, 0); expect_v("drain_sa_lag", SelSa, 1); check_sb();
    tick(1); expect_v("drain_sa_off", SelSa, 0); expect_v("drain_fault", SelFault, 0);
    check_sb();
    lamps(LY, LR); tick(1);
    lamps(LR, LR); tick(1);
    expect_v("legal_cycle_fault", SelFault, 0); check_sb();

    // Fill to capacity, then arrival+departure at max, then overflow
    arr_a = 1'b1;
    tick(15);
    expect_v("full_qa", SelQa, 15); expect_v("full_no_ovf", SelOvfA, 0); check_sb();
    arr_a = 1'b0;
    lamps(LG, LR); tick(1);
    arr_a = 1'b1; tick(1);
    expect_v("arrdep_qa", SelQa, 15); expect_v("arrdep_no_ovf", SelOvfA, 0); check_sb();
    arr_a = 1'b0;
    lamps(LY, LR); tick(1);
    expect_v("yellow_noserve", SelQa, 15); check_sb();
    lamps(LR, LR);
    arr_a = 1'b1; tick(1);
    arr_a = 1'b0;
    expect_v("ovf_qa", SelQa, 15); expect_v("ovf_a_set", SelOvfA, 1);
    expect_v("ovf_b_clear", SelOvfB, 0);
    check_sb();

    // Street B arrivals
    arr_b = 1'b1; tick(2);
    arr_b = 1'b0; tick(1);
    expect_v("b_qb", SelQb, 2); expect_v("b_sb", SelSb, 1); check_sb();

    // Illegal order: A green straight to red
    lamps(LG, LR); tick(1);
    expect_v("order_pre", SelFault, 0); check_sb();
    lamps(LR, LR); tick(1);
    expect_v("order_fault", SelFault, 1); expect_v("window_lost", SelQa, 15); check_sb();
    lamps(LR, LG); tick(4);
    expect_v("b_drain_qb", SelQb, 0); expect_v("fault_sticky", SelFault, 1); check_sb();

    // Mid-operation reset
    rst = 1'b1; tick(1);
    expect_v("mrst_qa", SelQa, 0); expect_v("mrst_ovf_a", SelOvfA, 0);
    expect_v("mrst_fault", SelFault, 0); expect_v("mrst_sa", SelSa, 0);
    check_sb();
    rst = 1'b0;

    // Arrival into an empty green queue departs two edges later
    lamps(LR, LY); tick(1);
    lamps(LR, LR); tick(1);
    lamps(LG, LR); tick(1);
    arr_a = 1'b1; tick(1);
    arr_a = 1'b0;
    expect_v("empty_arr", SelQa, 1); check_sb();
    tick(1); expect_v("empty_wait", SelQa, 1); check_sb();
    tick(1); expect_v("empty_dep", SelQa, 0); expect_v("empty_fault", SelFault, 0);
    check_sb();

    // Green conflict
    lamps(LG, LG); tick(1);
    expect_v("conflict", SelFault, 1); check_sb();
    lamps(LR, LR); tick(3);
    expect_v("conflict_sticky", SelFault, 1); check_sb();

    // Non-one-hot lamp vectors
    rst = 1'b1; lamps(LR, LR); tick(1);
    rst = 1'b0; tick(1);
    expect_v("dark_pre", SelFault, 0); check_sb();
    lamps(LOff, LR); tick(1);
    expect_v("dark_fault", SelFault, 1); check_sb();
    rst = 1'b1; lamps(LR, LR); tick(1);
    rst = 1'b0; tick(1);
    lamps(LR, LGY); tick(1);
    expect_v("gy_fault", SelFault, 1); check_sb();

    // Departure counting and peak tracking
    rst = 1'b1; lamps(LR, LR); tick(1);
    rst = 1'b0;
    arr_a = 1'b1; tick(7); arr_a = 1'b0;
    expect_v("peak_qa", SelQa, 7); check_sb();
    arr_b = 1'b1; tick(5); arr_b = 1'b0;
    expect_v("five_qb", SelQb, 5); check_sb();
    lamps(LR, LG); tick(10);
    expect_v("b_empty", SelQb, 0);
`ifdef INTERSECTION_STATS_EN
    expect_v("served_b", SelSrvB, 5);
    expect_v("max_qa_hold", SelMaxQa, 7);
`endif
    check_sb();
    lamps(LR, LY); tick(1);
    lamps(LR, LR); tick(1);
    lamps(LG, LR); tick(14);
    expect_v("a_empty", SelQa, 0); expect_v("stats_fault", SelFault, 0);
`ifdef INTERSECTION_STATS_EN
    expect_v("served_a", SelSrvA, 7);
    expect_v("max_qa_after", SelMaxQa, 7);
`endif
    check_sb();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
